full_adder_32bit: RTL and testbench

//  32-bit two's-complement/unsigned adder with carry-in, carry-out and signed overflow flag.

---
 rtl/full_adder_32bit.sv | 56 +++++
 tb/tb_full_adder_32bit.sv | 106 ++++++++++
 2 files changed

// File: rtl/full_adder_32bit.sv
// full_adder_32bit: 32-bit carry-lookahead adder (8 x 4-bit groups) with registered sum, carry-out and signed overflow
module full_adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_c;
  logic             w_ovf;
  assign w_g = a & b;
  assign w_p = a ^ b;
  // Lookahead carries inside each 4-bit group; each group's carry-out ripples into the next group
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int k = 0; k < WIDTH / 4; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
  end
  assign w_sum = w_p ^ w_c[WIDTH-1:0];
  assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  // Output register: result loads every cycle, valid follows in_valid, async clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= w_sum;
      cout      <= w_c[WIDTH];
      overflow  <= w_ovf;
      out_valid <= in_valid;
    end
  end
endmodule

// File: tb/tb_full_adder_32bit.sv
// tb_full_adder_32bit: directed and random checks of the registered 32-bit adder
module tb_full_adder_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        out_valid;
  logic [34:0] res;
  int          errs = 0;
  int          checks = 0;
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t vecs[11];
  full_adder_32bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .overflow(overflow), .out_valid(out_valid)
  );
  assign res = {out_valid, overflow, cout, sum};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got v/ovf/cout/sum=%h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [34:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic v);
    logic [32:0] s;
    logic        o;
    s = {1'b0, x} + {1'b0, y} + {32'b0, c};
    o = (x[31] == y[31]) && (s[31] != x[31]);
    return {v, o, s};
  endfunction
  initial begin
    vecs[0]  = '{32'h5,        32'hA,        1'b0, 32'h0000000F, 1'b0, 1'b0};
    vecs[1]  = '{32'h5,        32'hA,        1'b1, 32'h00000010, 1'b0, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4]  = '{32'hFFFFFFFF, 32'h1,        1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFB, 1'b1, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[7]  = '{32'h000FFFFF, 32'h00100000, 1'b0, 32'h001FFFFF, 1'b0, 1'b0};
    vecs[8]  = '{32'h7FFFFFFF, 32'h0,        1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hold", res, 35'h0);
    rst_n = 1'b1;
    #1 chk("reset_release_no_edge", res, 35'h0);
    @(negedge clk);
    chk("first_after_reset", res, {1'b1, 1'b0, 1'b1, 32'hFFFFFFFF});
    foreach (vecs[i]) begin
      a = vecs[i].x;
      b = vecs[i].y;
      cin = vecs[i].c;
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d", i), res, {1'b1, vecs[i].ov, vecs[i].co, vecs[i].s});
    end
    a = 32'h1;
    b = 32'h2;
    cin = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("invalid_cycle", res, {1'b0, 1'b0, 1'b0, 32'h3});
    a = 32'h3;
    b = 32'h4;
    in_valid = 1'b1;
    @(posedge clk);
    #1 chk("pre_midreset", res, {1'b1, 1'b0, 1'b0, 32'h7});
    #1 rst_n = 1'b0;
    #1 chk("midreset_immediate", res, 35'h0);
    @(negedge clk);
    @(negedge clk);
    chk("midreset_held", res, 35'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom_range(1));
      in_valid = 1'($urandom_range(1));
      if (i % 7 == 0) a = 32'h7FFFFFFF;
      if (i % 11 == 0) b = 32'hFFFFFFFF;
      @(negedge clk);
      chk($sformatf("rand%0d", i), res, ref_res(a, b, cin, in_valid));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
